serial_operand_feeder: RTL and testbench
========================================

// Module: serial_operand_feeder
// PURPOSE
//  Parallel-to-serial operand stage that feeds the bit-serial adder.
//  - Captures two WIDTH-bit operands and a carry-in on a start request.
//  - Presents them LSB-first, one bit pair per clock, with valid/first/last framing.
//  - A hold input stalls the stream. A one-cycle done pulse marks the end of a word.
// PARAMETERS
//  WIDTH  8  operand width in bits (legal range WIDTH >= 2)
// PORTS
//  clk        in   1      rising-edge clock; single clock domain
//  reset      in   1      asynchronous, active-high reset
//  start      in   1      load request; honoured only while ready=1
//  a_par      in   WIDTH  operand A, sampled on the accepting edge
//  b_par      in   WIDTH  operand B, sampled on the accepting edge
//  cin_in     in   1      word carry-in, sampled on the accepting edge
//  ready      out  1      1 in IDLE: feeder can accept start
//  a_ser      out  1      current bit of A (LSB first)
//  b_ser      out  1      current bit of B (LSB first)
//  cin_out    out  1      captured carry-in, held stable for the whole word
//  ser_valid  out  1      a_ser/b_ser carry a live bit this cycle
//  ser_first  out  1      1 while bit 0 is presented (adder loads its carry from cin_out)
//  ser_last   out  1      1 while bit WIDTH-1 is presented
//  done       out  1      one-cycle pulse after the last bit is consumed
// BEHAVIOUR
//  Reset values:
//  - Asserting reset forces state=IDLE, shift regs=0, count=0, cin reg=0.
//  - Outputs under reset: ready=1; a_ser=b_ser=cin_out=ser_valid=ser_first=ser_last=done=0.
//  - Reset mid-word aborts immediately. No done pulse. Partial word is discarded.
//  State machine: IDLE -> SHIFT -> DONE -> IDLE.
//  - IDLE: ready=1, ser_valid=0.
//    - Edge with start=1: load a_sh<=a_par, b_sh<=b_par, cin reg<=cin_in, count<=0, go SHIFT.
//    - Edge with start=0: stay in IDLE.
//  - SHIFT: ser_valid=1, a_ser=a_sh[0], b_ser=b_sh[0].
//    - ser_first=(count==0), ser_last=(count==WIDTH-1).
//    - Edge with hold=0 and count<WIDTH-1: shift a_sh and b_sh right by 1, count++.
//    - Edge with hold=0 and count==WIDTH-1: go DONE.
//    - Edge with hold=1: no change. Bit and flags stay stable, ser_valid stays 1.
//  - DONE: done=1, ser_valid=0, ready=0. Next edge goes to IDLE unconditionally.
//  Start handling:
//  - start outside IDLE (SHIFT or DONE) is ignored and not queued.
//  Outputs and latency:
//  - All outputs are decoded from registered state. No combinational path from inputs.
//    Exception: none. hold acts only at clock edges.
//  - cin_out is held stable from the accepting edge until the next accepted start.
//  - Bit 0 appears the cycle after the accepting edge.
//  - With no hold, a word occupies exactly WIDTH cycles of ser_valid, then 1 done cycle.
//  - Start-to-start minimum spacing is WIDTH+2 cycles.
//  Width rules:
//  - Shift regs are WIDTH bits. Zero fill enters at the MSB.
//  - count is $clog2(WIDTH) bits and never wraps past WIDTH-1.
//  - A hold raised on the last bit keeps ser_last=1 until it drops.
// TESTING
//  1 Reset: apply reset mid-run -> ready=1 and all other outputs 0 the same cycle;
//    after release, idle with no done.
//  2 Basic word, WIDTH=8: a_par=8'hA5, b_par=8'h3C, cin_in=1, start 1 cycle ->
//    - next 8 cycles: a_ser=1,0,1,0,0,1,0,1 and b_ser=0,0,1,1,1,1,0,0;
//    - ser_first on cycle 1 only, ser_last on cycle 8 only, cin_out=1 throughout;
//    - done pulses on cycle 9; ready=1 on cycle 10.
//  3 Hold: same load, hold=1 for 3 cycles while bit 2 is shown ->
//    - bit 2 (a=1, b=1) held stable for 4 cycles with ser_valid=1;
//    - total 11 valid cycles, done follows.
//  4 Busy start: pulse start with a_par=8'hFF during SHIFT and during DONE ->
//    ignored; the stream for the original operands is unchanged.
//  5 Back-to-back: start held high continuously ->
//    - words accepted every WIDTH+2 cycles;
//    - second word's cin_out changes only on its accepting edge.
//  6 WIDTH=2 boundary: a_par=2'b10, b_par=2'b01 ->
//    - a_ser=0,1 and b_ser=1,0;
//    - ser_first and ser_last on distinct cycles; done on cycle 3.

Source files
------------

// File: rtl/serial_operand_feeder_if.sv
// Bus bundle between an operand producer and the serial operand feeder.
//
// Handshake: a word transfers on a rising clk edge where start=1 and
// ready=1; a_par/b_par/cin_in are sampled on that edge only. start while
// ready=0 is dropped, never queued. On the serial side, a_ser/b_ser carry
// a live bit in every cycle with ser_valid=1. hold=1 on an edge freezes the
// presented bit and its framing flags for one more cycle.
interface serial_operand_feeder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_par;
  logic [WIDTH-1:0] b_par;
  logic             cin_in;
  logic             hold;
  logic             ready;
  logic             a_ser;
  logic             b_ser;
  logic             cin_out;
  logic             ser_valid;
  logic             ser_first;
  logic             ser_last;
  logic             done;
  logic [1:0]       state_dbg;

  // Producer / bench side
  modport master (
    output start, a_par, b_par, cin_in, hold,
    input  ready, a_ser, b_ser, cin_out, ser_valid, ser_first, ser_last, done,
    input  state_dbg
  );

  // Feeder side
  modport slave (
    input  start, a_par, b_par, cin_in, hold,
    output ready, a_ser, b_ser, cin_out, ser_valid, ser_first, ser_last, done,
    output state_dbg
  );
endinterface

// File: rtl/serial_operand_feeder.sv
// Parallel-to-serial operand stage for the bit-serial adder.
// Captures two WIDTH-bit operands plus a carry-in, then presents them
// LSB-first, one bit pair per clock, framed by ser_valid/ser_first/ser_last,
// followed by a single done cycle. All outputs decode registered state only.
module serial_operand_feeder #(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  serial_operand_feeder_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CW-1:0]    count;
  logic             cin_q;

  // Control FSM plus operand shift registers; zeros fill in at the MSB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      count <= '0;
      cin_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh  <= bus.a_par;
            b_sh  <= bus.b_par;
            cin_q <= bus.cin_in;
            count <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (!bus.hold) begin
            if (count == LAST) begin
              state <= DONE;
            end else begin
              a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
              b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
              count <= count + CW'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output decode: serial bits are gated so idle/done cycles show zeros.
  always_comb begin
    bus.ready     = (state == IDLE);
    bus.ser_valid = (state == SHIFT);
    bus.a_ser     = (state == SHIFT) & a_sh[0];
    bus.b_ser     = (state == SHIFT) & b_sh[0];
    bus.ser_first = (state == SHIFT) && (count == '0);
    bus.ser_last  = (state == SHIFT) && (count == LAST);
    bus.done      = (state == DONE);
    bus.cin_out   = cin_q;
    bus.state_dbg = state;
  end

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Bench for serial_operand_feeder: WIDTH=8 and WIDTH=2 instances share
// clock and reset. Directed table rows, randomized words, reset abort and
// back-to-back streaming are all checked against bench-side expectations.
module tb_serial_operand_feeder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  serial_operand_feeder_if #(.WIDTH(8)) if8 ();
  serial_operand_feeder_if #(.WIDTH(2)) if2 ();

  serial_operand_feeder #(.WIDTH(8)) u8 (.clk(clk), .reset(reset), .bus(if8.slave));
  serial_operand_feeder #(.WIDTH(2)) u2 (.clk(clk), .reset(reset), .bus(if2.slave));

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct packed {
    logic ready;
    logic a_ser;
    logic b_ser;
    logic cin_out;
    logic valid;
    logic first;
    logic last;
    logic done;
  } obs_t;

  function automatic obs_t observe(input int sel);
    obs_t o;
    if (sel == 0) o = '{if8.ready, if8.a_ser, if8.b_ser, if8.cin_out,
                        if8.ser_valid, if8.ser_first, if8.ser_last, if8.done};
    else          o = '{if2.ready, if2.a_ser, if2.b_ser, if2.cin_out,
                        if2.ser_valid, if2.ser_first, if2.ser_last, if2.done};
    return o;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input int sel, input logic st, input logic [7:0] a,
                       input logic [7:0] b, input logic cin, input logic hd);
    if (sel == 0) begin
      if8.start = st; if8.a_par = a; if8.b_par = b; if8.cin_in = cin; if8.hold = hd;
    end else begin
      if2.start = st; if2.a_par = a[1:0]; if2.b_par = b[1:0]; if2.cin_in = cin; if2.hold = hd;
    end
  endtask

  // ---------------- word runner with scoreboard ----------------
  typedef struct {
    int         sel;       // 0: WIDTH=8 instance, 1: WIDTH=2 instance
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    int         hold_at;   // bit index on which hold is raised
    int         hold_len;  // number of held edges (0 = no hold)
    logic       busy;      // pulse start with junk operands while busy
    logic [7:0] exp_a;     // bit i = a_ser value of the i-th presented bit
    logic [7:0] exp_b;
    int         done_cyc;  // 1-based cycle after the accepting edge with done=1
  } vec_t;

  task automatic run_word(input vec_t v);
    int   w;
    int   reps;
    logic hd;
    logic st;
    logic exp_valid;
    obs_t o;
    logic [3:0] exp_q[$];
    logic [3:0] e_item;
    w = (v.sel == 0) ? 8 : 2;
    for (int i = 0; i < w; i++) begin
      reps = (v.hold_len > 0 && i == v.hold_at) ? v.hold_len + 1 : 1;
      for (int r = 0; r < reps; r++)
        exp_q.push_back({v.exp_a[i], v.exp_b[i], (i == 0) ? 1'b1 : 1'b0, (i == w - 1) ? 1'b1 : 1'b0});
    end
    @(posedge clk); #1;
    drive(v.sel, 1'b1, v.a, v.b, v.cin, 1'b0);
    @(posedge clk); #1;  // accepting edge
    for (int e = 0; e <= v.done_cyc + 1; e++) begin
      hd = (v.hold_len > 0 && e >= v.hold_at && e < v.hold_at + v.hold_len);
      st = v.busy && (e <= v.done_cyc - 1);
      drive(v.sel, st, st ? 8'hFF : v.a, st ? 8'hFF : v.b, st ? ~v.cin : v.cin, hd);
      @(negedge clk);
      o = observe(v.sel);
      exp_valid = (e < v.done_cyc - 1);
      check("ser_valid", o.valid, exp_valid);
      if (exp_valid) begin
        if (exp_q.size() == 0) begin
          check("stream_len", 0, 1);
        end else begin
          e_item = exp_q.pop_front();
          check("bit_frame", {o.a_ser, o.b_ser, o.first, o.last}, e_item);
        end
      end
      check("done", o.done, (e == v.done_cyc - 1));
      check("ready", o.ready, (e >= v.done_cyc));
      check("cin_out", o.cin_out, v.cin);
      @(posedge clk); #1;
    end
    check("leftover_bits", exp_q.size(), 0);
    drive(v.sel, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  // ---------------- back-to-back streaming ----------------
  task automatic run_back_to_back();
    localparam int W = 8;
    localparam int P = W + 2;
    localparam int NW = 3;
    logic [7:0] ah[0:NW*P];
    logic [7:0] bh[0:NW*P];
    logic       ch[0:NW*P];
    logic [7:0] aw;
    logic [7:0] bw;
    int   m;
    int   base;
    obs_t o;
    @(posedge clk); #1;
    ah[0] = 8'($urandom); bh[0] = 8'($urandom); ch[0] = 1'($urandom);
    drive(0, 1'b1, ah[0], bh[0], ch[0], 1'b0);
    @(posedge clk); #1;  // first accepting edge
    for (int e = 0; e < NW * P; e++) begin
      if (e + 1 < NW * P) begin
        ah[e+1] = 8'($urandom); bh[e+1] = 8'($urandom); ch[e+1] = 1'($urandom);
        drive(0, 1'b1, ah[e+1], bh[e+1], ch[e+1], 1'b0);
      end else begin
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      end
      @(negedge clk);
      o = observe(0);
      m = e % P;
      base = (e / P) * P;
      aw = ah[base];
      bw = bh[base];
      check("b2b_valid", o.valid, (m < W));
      if (m < W) begin
        check("b2b_a", o.a_ser, aw[m]);
        check("b2b_b", o.b_ser, bw[m]);
        check("b2b_first", o.first, (m == 0));
        check("b2b_last", o.last, (m == W - 1));
      end
      check("b2b_done", o.done, (m == W));
      check("b2b_ready", o.ready, (m == W + 1));
      check("b2b_cin", o.cin_out, ch[base]);
      @(posedge clk); #1;
    end
  endtask

  // ---------------- main sequence ----------------
  vec_t tbl[6];
  vec_t rv;
  obs_t ro;

  initial begin
    tbl[0] = '{sel:0, a:8'hA5, b:8'h3C, cin:1'b1, hold_at:0, hold_len:0, busy:1'b0,
               exp_a:8'b1010_0101, exp_b:8'b0011_1100, done_cyc:9};
    tbl[1] = '{sel:0, a:8'hA5, b:8'h3C, cin:1'b1, hold_at:2, hold_len:3, busy:1'b0,
               exp_a:8'b1010_0101, exp_b:8'b0011_1100, done_cyc:12};
    tbl[2] = '{sel:0, a:8'hA5, b:8'h3C, cin:1'b1, hold_at:0, hold_len:0, busy:1'b1,
               exp_a:8'b1010_0101, exp_b:8'b0011_1100, done_cyc:9};
    tbl[3] = '{sel:1, a:8'h02, b:8'h01, cin:1'b0, hold_at:0, hold_len:0, busy:1'b0,
               exp_a:8'b0000_0010, exp_b:8'b0000_0001, done_cyc:3};
    tbl[4] = '{sel:1, a:8'h03, b:8'h00, cin:1'b1, hold_at:1, hold_len:2, busy:1'b1,
               exp_a:8'b0000_0011, exp_b:8'b0000_0000, done_cyc:5};
    tbl[5] = '{sel:0, a:8'h00, b:8'hFF, cin:1'b0, hold_at:7, hold_len:2, busy:1'b0,
               exp_a:8'b0000_0000, exp_b:8'b1111_1111, done_cyc:11};

    reset = 1'b1;
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    drive(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("reset_out_w8", observe(0), 8'b1000_0000);
    check("reset_out_w2", observe(1), 8'b1000_0000);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_word(tbl[i]);

    // Randomized words on both widths
    for (int i = 0; i < 24; i++) begin
      rv.sel      = i % 2;
      rv.a        = 8'($urandom);
      rv.b        = 8'($urandom);
      if (rv.sel == 1) begin
        rv.a = rv.a & 8'h03;
        rv.b = rv.b & 8'h03;
      end
      rv.cin      = 1'($urandom);
      rv.hold_at  = $urandom_range(0, (rv.sel == 0) ? 7 : 1);
      rv.hold_len = $urandom_range(0, 3);
      rv.busy     = 1'($urandom);
      rv.exp_a    = rv.a;
      rv.exp_b    = rv.b;
      rv.done_cyc = ((rv.sel == 0) ? 8 : 2) + rv.hold_len + 1;
      run_word(rv);
    end

    run_back_to_back();

    // Reset in the middle of a word aborts it without a done pulse
    @(posedge clk); #1;
    drive(0, 1'b1, 8'h5A, 8'hC3, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1 ro = observe(0);
    check("midword_reset", ro, 8'b1000_0000);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_reset_idle", observe(0), 8'b1000_0000);
    end

    // Normal operation resumes after the abort
    run_word(tbl[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
